// File: rtl/ofdm_qam_mapper.sv
// ofdm_qam_mapper
//   Packs the serial cipher bit stream into BPSK / QPSK / 16-QAM constellation
//   points. Each point leaves as one signed I/Q sample per subcarrier, tagged
//   with its subcarrier index and a frame-last marker. A flush request pads a
//   partial frame with zero bits up to the frame boundary.
//
// Parameters
//   BITS_PER_SYM   : bits per constellation point (1, 2 or 4)
//   NO_SUBCARRIERS : symbols per OFDM frame (>= 2)
//   IQ_WIDTH       : signed width of sym_i / sym_q (>= 4)
//
// Ports
//   ofdm_clk        : the only clock
//   resetn          : synchronous, active-low reset
//   ofdm_sdata_vld  : serial bit valid
//   ofdm_sdata_rdy  : serial bit ready (combinational from sym_rdy)
//   ofdm_sdata      : serial cipher bit, first bit of a symbol is its MSB
//   frame_flush     : single-cycle request to pad and close the current frame
//   sym_vld/sym_rdy : symbol handshake toward the IFFT stage
//   sym_i / sym_q   : signed in-phase / quadrature sample
//   sym_idx         : subcarrier index of the current symbol
//   sym_last        : high with the symbol at index NO_SUBCARRIERS-1
//   frame_cnt       : completed frames, wraps 65535 -> 0
module ofdm_qam_mapper #(
    parameter int BITS_PER_SYM   = 2,
    parameter int NO_SUBCARRIERS = 64,
    parameter int IQ_WIDTH       = 8
) (
    input  logic                              ofdm_clk,
    input  logic                              resetn,
    input  logic                              ofdm_sdata_vld,
    output logic                              ofdm_sdata_rdy,
    input  logic                              ofdm_sdata,
    input  logic                              frame_flush,
    output logic                              sym_vld,
    input  logic                              sym_rdy,
    output logic [IQ_WIDTH-1:0]               sym_i,
    output logic [IQ_WIDTH-1:0]               sym_q,
    output logic [$clog2(NO_SUBCARRIERS)-1:0] sym_idx,
    output logic                              sym_last,
    output logic [15:0]                       frame_cnt
);

    localparam int IDXW = $clog2(NO_SUBCARRIERS);
    localparam int CNTW = (BITS_PER_SYM > 1) ? $clog2(BITS_PER_SYM) : 1;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NO_SUBCARRIERS - 1);
    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(BITS_PER_SYM - 1);

    localparam logic [IQ_WIDTH-1:0] POS_A  = IQ_WIDTH'(2 ** (IQ_WIDTH - 2));
    localparam logic [IQ_WIDTH-1:0] NEG_A  = IQ_WIDTH'(-(2 ** (IQ_WIDTH - 2)));
    localparam logic [IQ_WIDTH-1:0] POS_U  = IQ_WIDTH'(2 ** (IQ_WIDTH - 3));
    localparam logic [IQ_WIDTH-1:0] NEG_U  = IQ_WIDTH'(-(2 ** (IQ_WIDTH - 3)));
    localparam logic [IQ_WIDTH-1:0] POS_3U = IQ_WIDTH'(3 * 2 ** (IQ_WIDTH - 3));
    localparam logic [IQ_WIDTH-1:0] NEG_3U = IQ_WIDTH'(-(3 * 2 ** (IQ_WIDTH - 3)));

    generate
        if (BITS_PER_SYM != 1 && BITS_PER_SYM != 2 && BITS_PER_SYM != 4) begin : g_bad_bps
            $error("ofdm_qam_mapper: BITS_PER_SYM must be 1, 2 or 4");
        end
        if (NO_SUBCARRIERS < 2) begin : g_bad_nsc
            $error("ofdm_qam_mapper: NO_SUBCARRIERS must be >= 2");
        end
        if (IQ_WIDTH < 4) begin : g_bad_iqw
            $error("ofdm_qam_mapper: IQ_WIDTH must be >= 4");
        end
    endgenerate

    typedef enum logic {
        COLLECT = 1'b0,
        PAD     = 1'b1
    } state_t;

    state_t                    state, state_nxt;
    logic [BITS_PER_SYM-1:0]   acc, acc_nxt, acc_w, load_bits;
    logic [CNTW-1:0]           bit_cnt, bit_cnt_nxt;
    logic                      flush_pend, flush_nxt;
    logic                      rdy_en;
    logic [IDXW-1:0]           next_idx, next_idx_inc, idx_after;
    logic                      load;
    logic                      out_free;
    logic                      flush_req;

    // Gray-coded 16-QAM amplitude: 00 -3u, 01 -u, 11 +u, 10 +3u
    function automatic logic [IQ_WIDTH-1:0] qam16_level(input logic [1:0] b);
        case (b)
            2'b00:   qam16_level = NEG_3U;
            2'b01:   qam16_level = NEG_U;
            2'b11:   qam16_level = POS_U;
            default: qam16_level = POS_3U;
        endcase
    endfunction

    // Returns {I, Q}; bits are left-aligned so b[BITS_PER_SYM-1] is b0
    function automatic logic [2*IQ_WIDTH-1:0] map_iq(input logic [BITS_PER_SYM-1:0] b);
        logic [3:0] b4;
        b4 = '0;
        b4[3 -: BITS_PER_SYM] = b;
        if (BITS_PER_SYM == 1)
            map_iq = {(b4[3] ? NEG_A : POS_A), {IQ_WIDTH{1'b0}}};
        else if (BITS_PER_SYM == 2)
            map_iq = {(b4[3] ? NEG_A : POS_A), (b4[2] ? NEG_A : POS_A)};
        else
            map_iq = {qam16_level(b4[3:2]), qam16_level(b4[1:0])};
    endfunction

    assign out_free     = !sym_vld || sym_rdy;
    assign next_idx_inc = (next_idx == LAST_IDX) ? '0 : next_idx + 1'b1;

    always_comb begin
        state_nxt      = state;
        acc_nxt        = acc;
        acc_w          = acc;
        bit_cnt_nxt    = bit_cnt;
        flush_nxt      = flush_pend;
        load           = 1'b0;
        load_bits      = acc;
        ofdm_sdata_rdy = 1'b0;
        flush_req      = 1'b0;
        idx_after      = next_idx;

        case (state)
            COLLECT: begin
                ofdm_sdata_rdy = rdy_en && out_free;
                flush_req      = flush_pend || frame_flush;
                // Bits fill the accumulator MSB-first, so unfilled LSBs are
                // already zero when a partial symbol gets padded.
                if (ofdm_sdata_vld && ofdm_sdata_rdy) begin
                    for (int unsigned k = 0; k < BITS_PER_SYM; k++) begin
                        if (CNTW'(k) == bit_cnt)
                            acc_w[BITS_PER_SYM-1-k] = ofdm_sdata;
                    end
                    if (bit_cnt == LAST_BIT) begin
                        load        = 1'b1;
                        load_bits   = acc_w;
                        acc_nxt     = '0;
                        bit_cnt_nxt = '0;
                    end else begin
                        acc_nxt     = acc_w;
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
                if (load)
                    idx_after = next_idx_inc;
                if (flush_req) begin
                    // No empty frames: nothing buffered and sitting on a boundary
                    if (bit_cnt_nxt == '0 && idx_after == '0) begin
                        flush_nxt = 1'b0;
                    end else begin
                        flush_nxt = 1'b1;
                        state_nxt = PAD;
                    end
                end
            end
            PAD: begin
                if (out_free) begin
                    load        = 1'b1;
                    load_bits   = acc;
                    acc_nxt     = '0;
                    bit_cnt_nxt = '0;
                    if (next_idx == LAST_IDX) begin
                        state_nxt = COLLECT;
                        flush_nxt = 1'b0;
                    end
                end
            end
            default: state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge ofdm_clk) begin
        if (!resetn)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    always_ff @(posedge ofdm_clk) begin
        if (!resetn) begin
            acc        <= '0;
            bit_cnt    <= '0;
            flush_pend <= 1'b0;
            rdy_en     <= 1'b0;
            next_idx   <= '0;
            sym_vld    <= 1'b0;
            sym_i      <= '0;
            sym_q      <= '0;
            sym_idx    <= '0;
            sym_last   <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            acc        <= acc_nxt;
            bit_cnt    <= bit_cnt_nxt;
            flush_pend <= flush_nxt;
            rdy_en     <= 1'b1;
            if (load) begin
                sym_vld        <= 1'b1;
                {sym_i, sym_q} <= map_iq(load_bits);
                sym_idx        <= next_idx;
                sym_last       <= (next_idx == LAST_IDX);
                next_idx       <= next_idx_inc;
            end else if (sym_rdy) begin
                sym_vld <= 1'b0;
            end
            if (sym_vld && sym_rdy && sym_last)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_ofdm_qam_mapper.sv
// tb_ofdm_qam_mapper
//   Directed bench for ofdm_qam_mapper: a default QPSK instance plus 16-QAM and
//   BPSK instances sharing the same input stimulus.
module tb_ofdm_qam_mapper;

    logic       clk = 1'b0;
    logic       resetn;
    logic       vld;
    logic       sdata;
    logic       flush;
    logic       sym_rdy;

    logic       d_rdy, d_vld, d_last;
    logic [7:0] d_i, d_q;
    logic [5:0] d_idx;
    logic [15:0] d_fcnt;

    logic       q4_rdy, q4_vld, q4_last;
    logic [7:0] q4_i, q4_q;
    logic [5:0] q4_idx;
    logic [15:0] q4_fcnt;

    logic       b1_rdy, b1_vld, b1_last;
    logic [7:0] b1_i, b1_q;
    logic [5:0] b1_idx;
    logic [15:0] b1_fcnt;

    int n_run  = 0;
    int n_fail = 0;

    localparam logic [7:0] P64 = 8'h40;
    localparam logic [7:0] N64 = 8'hC0;
    localparam logic [7:0] P96 = 8'h60;
    localparam logic [7:0] N96 = 8'hA0;
    localparam logic [7:0] N32 = 8'hE0;

    always #5 clk = ~clk;

    ofdm_qam_mapper #(.BITS_PER_SYM(2), .NO_SUBCARRIERS(64), .IQ_WIDTH(8)) u_qpsk (
        .ofdm_clk(clk), .resetn(resetn), .ofdm_sdata_vld(vld), .ofdm_sdata_rdy(d_rdy),
        .ofdm_sdata(sdata), .frame_flush(flush), .sym_vld(d_vld), .sym_rdy(sym_rdy),
        .sym_i(d_i), .sym_q(d_q), .sym_idx(d_idx), .sym_last(d_last), .frame_cnt(d_fcnt)
    );

    ofdm_qam_mapper #(.BITS_PER_SYM(4), .NO_SUBCARRIERS(64), .IQ_WIDTH(8)) u_qam16 (
        .ofdm_clk(clk), .resetn(resetn), .ofdm_sdata_vld(vld), .ofdm_sdata_rdy(q4_rdy),
        .ofdm_sdata(sdata), .frame_flush(flush), .sym_vld(q4_vld), .sym_rdy(sym_rdy),
        .sym_i(q4_i), .sym_q(q4_q), .sym_idx(q4_idx), .sym_last(q4_last), .frame_cnt(q4_fcnt)
    );

    ofdm_qam_mapper #(.BITS_PER_SYM(1), .NO_SUBCARRIERS(64), .IQ_WIDTH(8)) u_bpsk (
        .ofdm_clk(clk), .resetn(resetn), .ofdm_sdata_vld(vld), .ofdm_sdata_rdy(b1_rdy),
        .ofdm_sdata(sdata), .frame_flush(flush), .sym_vld(b1_vld), .sym_rdy(sym_rdy),
        .sym_i(b1_i), .sym_q(b1_q), .sym_idx(b1_idx), .sym_last(b1_last), .frame_cnt(b1_fcnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_sym(input string tag, input logic [7:0] ei, input logic [7:0] eq,
                           input logic [5:0] eidx, input logic elast);
        chk({tag, "_vld"}, 16'(d_vld), 16'd1);
        chk({tag, "_i"}, 16'(d_i), 16'(ei));
        chk({tag, "_q"}, 16'(d_q), 16'(eq));
        chk({tag, "_idx"}, 16'(d_idx), 16'(eidx));
        chk({tag, "_last"}, 16'(d_last), 16'(elast));
    endtask

    task automatic send_bit(input logic b);
        sdata = b;
        vld   = 1'b1;
        tick();
    endtask

    initial begin
        logic       t1_bits [8];
        logic [7:0] t1_i    [4];
        logic [7:0] t1_q    [4];
        t1_bits = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        t1_i    = '{P64, N64, P64, N64};
        t1_q    = '{P64, N64, N64, P64};

        resetn  = 1'b0;
        vld     = 1'b0;
        sdata   = 1'b0;
        flush   = 1'b0;
        sym_rdy = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_vld", 16'(d_vld), 16'd0);
        chk("rst_i", 16'(d_i), 16'd0);
        chk("rst_q", 16'(d_q), 16'd0);
        chk("rst_idx", 16'(d_idx), 16'd0);
        chk("rst_last", 16'(d_last), 16'd0);
        chk("rst_fcnt", d_fcnt, 16'd0);
        chk("rst_rdy", 16'(d_rdy), 16'd0);
        resetn = 1'b1;
        #1;
        chk("rdy_before_edge", 16'(d_rdy), 16'd0);
        tick();
        chk("rdy_after_release", 16'(d_rdy), 16'd1);

        // Test 1: four QPSK symbols, one cycle latency after the second bit
        for (int p = 0; p < 4; p++) begin
            send_bit(t1_bits[2*p]);
            chk("t1_vld_low_mid_pair", 16'(d_vld), 16'd0);
            send_bit(t1_bits[2*p+1]);
            chk_sym("t1_sym", t1_i[p], t1_q[p], 6'(p), 1'b0);
        end

        // Test 2: backpressure holds outputs and blocks input
        sym_rdy = 1'b0;
        sdata   = 1'b1;
        #1;
        chk("t2_rdy_blocked", 16'(d_rdy), 16'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_sym("t2_hold", N64, P64, 6'd3, 1'b0);
            chk("t2_rdy_hold", 16'(d_rdy), 16'd0);
        end
        sym_rdy = 1'b1;
        #1;
        chk("t2_rdy_comb", 16'(d_rdy), 16'd1);
        tick();
        chk("t2_vld_drop", 16'(d_vld), 16'd0);
        send_bit(1'b0);
        chk_sym("t2_next", N64, P64, 6'd4, 1'b0);

        // Test 3: fill the frame, sym_last only at 63, frame_cnt on its handshake
        for (int k = 5; k < 64; k++) begin
            send_bit(1'b0);
            send_bit(1'b0);
            chk_sym("t3_sym", P64, P64, 6'(k), (k == 63));
        end
        chk("t3_fcnt_before", d_fcnt, 16'd0);
        send_bit(1'b0);
        chk("t3_fcnt_after", d_fcnt, 16'd1);
        chk("t3_vld_gap", 16'(d_vld), 16'd0);
        send_bit(1'b0);
        chk_sym("t3_wrap", P64, P64, 6'd0, 1'b0);

        // Test 4: partial symbol then flush, pad to end of frame
        vld    = 1'b0;
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        send_bit(1'b1);
        send_bit(1'b0);
        chk_sym("t4_s0", N64, P64, 6'd0, 1'b0);
        send_bit(1'b1);
        vld   = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        vld   = 1'b1;
        sdata = 1'b1;
        #1;
        chk("t4_pad_rdy", 16'(d_rdy), 16'd0);
        chk("t4_pad_vld0", 16'(d_vld), 16'd0);
        for (int k = 1; k < 64; k++) begin
            flush = (k == 30);
            tick();
            chk_sym("t4_pad", (k == 1) ? N64 : P64, P64, 6'(k), (k == 63));
            chk("t4_pad_rdy_seq", 16'(d_rdy), 16'(k == 63));
        end
        flush = 1'b0;
        vld   = 1'b0;
        tick();
        chk("t4_fcnt", d_fcnt, 16'd1);
        chk("t4_vld_after", 16'(d_vld), 16'd0);
        chk("t4_rdy_after", 16'(d_rdy), 16'd1);
        // Flush on an empty frame boundary is dropped
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_empty_flush_rdy", 16'(d_rdy), 16'd1);
        chk("t4_empty_flush_vld", 16'(d_vld), 16'd0);
        tick();
        chk("t4_empty_flush_vld2", 16'(d_vld), 16'd0);

        // Test 5: 16-QAM and BPSK mapping
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        send_bit(1'b1);
        chk("t5_b1_vld", 16'(b1_vld), 16'd1);
        chk("t5_b1_i", 16'(b1_i), 16'(N64));
        chk("t5_b1_q", 16'(b1_q), 16'd0);
        chk("t5_b1_idx", 16'(b1_idx), 16'd0);
        send_bit(1'b0);
        chk("t5_b1_i0", 16'(b1_i), 16'(P64));
        chk("t5_b1_idx1", 16'(b1_idx), 16'd1);
        chk("t5_q4_vld_early", 16'(q4_vld), 16'd0);
        send_bit(1'b0);
        send_bit(1'b1);
        chk("t5_q4_vld", 16'(q4_vld), 16'd1);
        chk("t5_q4_i", 16'(q4_i), 16'(P96));
        chk("t5_q4_q", 16'(q4_q), 16'(N32));
        chk("t5_q4_idx", 16'(q4_idx), 16'd0);
        send_bit(1'b1);
        vld   = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("t5_q4_pad_i", 16'(q4_i), 16'(P96));
        chk("t5_q4_pad_q", 16'(q4_q), 16'(N96));
        chk("t5_q4_pad_idx", 16'(q4_idx), 16'd1);
        tick();
        chk("t5_q4_zero_i", 16'(q4_i), 16'(N96));
        chk("t5_q4_zero_q", 16'(q4_q), 16'(N96));
        chk("t5_q4_zero_idx", 16'(q4_idx), 16'd2);

        // Test 6: reset mid-frame with a pending bit
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        for (int s = 0; s < 11; s++) begin
            send_bit(1'b0);
            send_bit(1'b0);
        end
        chk_sym("t6_pre", P64, P64, 6'd10, 1'b0);
        send_bit(1'b1);
        chk("t6_pending_vld", 16'(d_vld), 16'd0);
        vld    = 1'b0;
        resetn = 1'b0;
        tick();
        chk("t6_rst_vld", 16'(d_vld), 16'd0);
        chk("t6_rst_i", 16'(d_i), 16'd0);
        chk("t6_rst_q", 16'(d_q), 16'd0);
        chk("t6_rst_idx", 16'(d_idx), 16'd0);
        chk("t6_rst_last", 16'(d_last), 16'd0);
        chk("t6_rst_fcnt", d_fcnt, 16'd0);
        chk("t6_rst_rdy", 16'(d_rdy), 16'd0);
        resetn = 1'b1;
        tick();
        send_bit(1'b0);
        send_bit(1'b1);
        chk_sym("t6_fresh", P64, N64, 6'd0, 1'b0);
        chk("t6_fcnt", d_fcnt, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
